rand_arbiter: RTL and testbench

Shared random-number controller for the bomb game. It owns one 8-bit linear congruential generator and shares it among up to N_REQ game requesters (bomb placement, item drop, enemy movement, …). Arbitration between requesters is round-robin. Each request carries a range bound, and the block returns a value uniformly drawn in [0, bound) using rejection sampling with a bounded retry count. It sits between the game-logic FSMs and the generator state.

---
 rtl/rand_pkg.sv | 27 ++
 rtl/lcg_core.sv | 39 +++
 rtl/rand_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rand_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and defaults for the random-number arbiter: FSM encoding,
// generator constants and the rejection-sampling mask helper.
package rand_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StCheck,
        StGrant
    } state_e;

    localparam logic [7:0]  DefSeed     = 8'd8;
    localparam logic [7:0]  DefMult     = 8'd5;
    localparam logic [7:0]  DefInc      = 8'd3;
    localparam int unsigned DefMaxTries = 4;

    // Smallest 2^k-1 covering bound-1; bound 0 stands for 256 and wraps to 8'hFF.
    function automatic logic [7:0] mask_from_bound(input logic [7:0] b);
        logic [7:0] m;
        m = b - 8'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/lcg_core.sv
// 8-bit linear congruential generator: state = state*MULT + INC (mod 256),
// with a synchronous load that takes priority over stepping.
module lcg_core
    import rand_pkg::*;
#(
    parameter logic [7:0] SEED = DefSeed,
    parameter logic [7:0] MULT = DefMult,
    parameter logic [7:0] INC  = DefInc
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] seed_val_i,
    input  logic       step_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_val_i;
        end else if (step_i) begin
            state_d = 8'(({8'h00, state_q} * {8'h00, MULT}) + {8'h00, INC});
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin front end sharing one LCG among N_REQ requesters; each grant
// returns a value in [0, bound) via masked rejection sampling with fallback.
module rand_arbiter
    import rand_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter logic [7:0]  SEED      = DefSeed,
    parameter logic [7:0]  MULT      = DefMult,
    parameter logic [7:0]  INC       = DefInc,
    parameter int unsigned MAX_TRIES = DefMaxTries
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] bound,
    input  logic               reseed,
    input  logic [7:0]         seed_val,
    output logic [N_REQ-1:0]   gnt,
    output logic [7:0]         rand_out,
    output logic               busy
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic [7:0]        bnd_q, bnd_d;
    logic [7:0]        mask_q, mask_d;
    logic [3:0]        tries_q, tries_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [7:0]        rand_out_q, rand_out_d;
    logic              busy_q, busy_d;

    logic              lcg_load, lcg_step;
    logic [7:0]        lcg_state;
    logic [7:0]        cand;
    logic              accept;
    logic [7:0]        bound_arr [N_REQ];

    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;
    int unsigned       rr_sum;
    logic [IdxW-1:0]   rr_idx;

    lcg_core #(
        .SEED (SEED),
        .MULT (MULT),
        .INC  (INC)
    ) u_lcg (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (lcg_load),
        .seed_val_i (seed_val),
        .step_i     (lcg_step),
        .state_o    (lcg_state)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_bound
        assign bound_arr[g] = bound[8*g +: 8];
    end

    // First set request at or after the pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_sum     = 0;
        rr_idx     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rr_sum = 32'(ptr_q) + i;
            if (rr_sum >= N_REQ) begin
                rr_sum = rr_sum - N_REQ;
            end
            rr_idx = IdxW'(rr_sum);
            if (!pick_valid && req[rr_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_idx;
            end
        end
    end

    assign cand   = lcg_state & mask_q;
    assign accept = (bnd_q == 8'd0) || (cand < bnd_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        bnd_d      = bnd_q;
        mask_d     = mask_q;
        tries_d    = tries_q;
        gnt_d      = '0;
        rand_out_d = rand_out_q;
        lcg_load   = 1'b0;
        lcg_step   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (reseed) begin
                    lcg_load = 1'b1;
                end else if (pick_valid) begin
                    win_d   = pick_idx;
                    bnd_d   = bound_arr[pick_idx];
                    mask_d  = mask_from_bound(bound_arr[pick_idx]);
                    tries_d = '0;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                lcg_step = 1'b1;
                tries_d  = tries_q + 4'd1;
                state_d  = StCheck;
            end
            StCheck: begin
                if (accept) begin
                    rand_out_d   = cand;
                    gnt_d[win_q] = 1'b1;
                    state_d      = StGrant;
                end else if (tries_q == 4'(MAX_TRIES)) begin
                    // cand < 2*bound here, so the folded value stays in range.
                    rand_out_d   = cand - bnd_q;
                    gnt_d[win_q] = 1'b1;
                    state_d      = StGrant;
                end else begin
                    state_d = StDraw;
                end
            end
            StGrant: begin
                ptr_d   = (win_q == IdxW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            win_q      <= '0;
            bnd_q      <= '0;
            mask_q     <= '0;
            tries_q    <= '0;
            gnt_q      <= '0;
            rand_out_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            bnd_q      <= bnd_d;
            mask_q     <= mask_d;
            tries_q    <= tries_d;
            gnt_q      <= gnt_d;
            rand_out_q <= rand_out_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign rand_out = rand_out_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter: drivers queue expected grants, monitors
// check them when gnt pulses. A second instance runs with MAX_TRIES=1.
module tb_rand_arbiter;

    typedef struct {
        int         idx;
        logic [7:0] val;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    bit          done1 = 1'b0;

    logic        rst0 = 1'b0;
    logic [3:0]  req0 = '0;
    logic [31:0] bound0 = '0;
    logic        reseed0 = 1'b0;
    logic [7:0]  seed_val0 = '0;
    logic [3:0]  gnt0;
    logic [7:0]  rand_out0;
    logic        busy0;

    logic        rst1 = 1'b0;
    logic [3:0]  req1 = '0;
    logic [31:0] bound1 = '0;
    logic [3:0]  gnt1;
    logic [7:0]  rand_out1;
    logic        busy1;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rand_arbiter dut (
        .clk      (clk),
        .rst      (rst0),
        .req      (req0),
        .bound    (bound0),
        .reseed   (reseed0),
        .seed_val (seed_val0),
        .gnt      (gnt0),
        .rand_out (rand_out0),
        .busy     (busy0)
    );

    rand_arbiter #(.MAX_TRIES(1)) dut1 (
        .clk      (clk),
        .rst      (rst1),
        .req      (req1),
        .bound    (bound1),
        .reseed   (1'b0),
        .seed_val (8'h00),
        .gnt      (gnt1),
        .rand_out (rand_out1),
        .busy     (busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [7:0] v,
                               inout exp_t q[$]);
        exp_t e;
        logic [3:0] eg;
        if (q.size() == 0) begin
            chk({tag, "_unexpected_gnt"}, 32'(g), 32'h0);
        end else begin
            e  = q.pop_front();
            eg = 4'b0001 << e.idx;
            chk({tag, "_gnt"}, 32'(g), 32'(eg));
            chk({tag, "_rand_out"}, 32'(v), 32'(e.val));
            if (e.due >= 0) chk({tag, "_gnt_cycle"}, 32'(cyc), 32'(e.due));
        end
    endtask

    always @(negedge clk) if (gnt0 != 4'b0) check_grant("dut", gnt0, rand_out0, q0);
    always @(negedge clk) if (gnt1 != 4'b0) check_grant("dut1", gnt1, rand_out1, q1);

    task automatic reset0();
        rst0 = 1'b0;
        req0 = '0;
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt0), 32'h0);
        chk("reset_rand_out", 32'(rand_out0), 32'h0);
        chk("reset_busy", 32'(busy0), 32'h0);
        rst0 = 1'b1;
    endtask

    // Single request with a known number of rejected draws; optional reseed pulse while busy.
    task automatic do_req(input int idx, input logic [7:0] bnd, input logic [7:0] val,
                          input int rej, input bit busy_reseed);
        int k;
        int due;
        bit seen;
        @(negedge clk);
        bound0[8*idx +: 8] = bnd;
        req0[idx] = 1'b1;
        k   = cyc + 1;
        due = k + 2 + 2 * rej;
        q0.push_back('{idx, val, due});
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (busy_reseed && cyc == k) begin
                reseed0   = 1'b1;
                seed_val0 = 8'h77;
            end else begin
                reseed0 = 1'b0;
            end
            if (cyc <= due) chk("busy_active", 32'(busy0), 32'h1);
            if (gnt0[idx]) begin
                seen      = 1'b1;
                req0[idx] = 1'b0;
            end
        end
        reseed0 = 1'b0;
        if (!seen) chk("grant_timeout", 32'h0, 32'h1);
        @(negedge clk);
        chk("busy_after_grant", 32'(busy0), 32'h0);
        chk("gnt_after_grant", 32'(gnt0), 32'h0);
    endtask

    initial begin
        int k;
        reset0();
        do_req(0, 8'd0, 8'd43, 0, 1'b0);
        do_req(1, 8'd6, 8'd2, 0, 1'b0);

        reset0();
        do_req(2, 8'd3, 8'd2, 1, 1'b0);

        // All four held; each drops on its own grant.
        reset0();
        @(negedge clk);
        bound0 = '0;
        req0   = 4'b1111;
        q0.push_back('{0, 8'd43, -1});
        q0.push_back('{1, 8'd218, -1});
        q0.push_back('{2, 8'd69, -1});
        q0.push_back('{3, 8'd92, -1});
        for (int t = 0; t < 100 && req0 != 4'b0; t++) begin
            @(negedge clk);
            req0 = req0 & ~gnt0;
        end
        chk("rr_all_served", 32'(req0), 32'h0);
        req0 = '0;
        @(negedge clk);

        // Reseed in idle restarts the sequence; reseed while busy is dropped.
        reseed0   = 1'b1;
        seed_val0 = 8'd8;
        @(negedge clk);
        reseed0 = 1'b0;
        do_req(0, 8'd0, 8'd43, 0, 1'b0);
        do_req(0, 8'd0, 8'd218, 0, 1'b1);

        // Reset in the middle of a draw: request lost, generator back to seed.
        @(negedge clk);
        bound0[7:0] = 8'd0;
        req0[0] = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        chk("pre_reset_in_draw", 32'(cyc), 32'(k));
        rst0 = 1'b0;
        req0 = '0;
        repeat (3) begin
            @(negedge clk);
            chk("midreq_reset_gnt", 32'(gnt0), 32'h0);
            chk("midreq_reset_rand_out", 32'(rand_out0), 32'h0);
            chk("midreq_reset_busy", 32'(busy0), 32'h0);
        end
        rst0 = 1'b1;
        do_req(0, 8'd0, 8'd43, 0, 1'b0);

        for (int t = 0; t < 200 && !done1; t++) @(negedge clk);
        chk("dut1_done", 32'(done1), 32'h1);
        repeat (2) @(negedge clk);
        chk("dut_queue_drained", 32'(q0.size()), 32'h0);
        chk("dut1_queue_drained", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // MAX_TRIES=1: first draw 43 & 3 = 3 is rejected and folded to 3-3 = 0.
    initial begin
        int k;
        bit seen;
        rst1 = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        bound1[23:16] = 8'd3;
        req1[2] = 1'b1;
        k = cyc + 1;
        q1.push_back('{2, 8'd0, k + 2});
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (gnt1[2]) begin
                seen    = 1'b1;
                req1[2] = 1'b0;
            end
        end
        if (!seen) chk("dut1_grant_timeout", 32'h0, 32'h1);
        done1 = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
